// File: rtl/nibble_pkg.sv
// Shared constants and elaboration helpers for the nibble packer slice.
package nibble_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int DEF_NIBBLES    = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Smallest r with 2**r >= value; used to validate address widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with level, full and empty flags.
module sync_fifo
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop && !w_empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/nibble_packer.sv
// Packs incoming 4-bit nibbles MSB-first into wide words and queues them
// for a valid/ready consumer, with a sticky flag for dropped words.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int NIBBLES    = DEF_NIBBLES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_AW    = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NIBBLE_W-1:0]       in_data,
  input  logic                      in_valid,
  output logic [NIBBLE_W*NIBBLES-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FIFO_AW:0]          level,
  output logic                      overflow,
  input  logic                      overflow_clr
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = clog2(NIBBLES);

  generate
    if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
      $error("nibble_packer: NIBBLES must be in 2..8");
    end
    if (FIFO_DEPTH < 2 || (1 << FIFO_AW) != FIFO_DEPTH || clog2(FIFO_DEPTH) != FIFO_AW) begin : g_bad_depth
      $error("nibble_packer: FIFO_DEPTH must be a power of two >= 2 and FIFO_AW its log2");
    end
  endgenerate

  // Only the older nibbles need storing; the newest comes straight from in_data.
  logic [W-NIBBLE_W-1:0] r_shift;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic [W-1:0]     w_word;
  logic             w_word_done;
  logic             w_pop;
  logic             w_drop;
  logic [W-1:0]     w_head;
  logic             w_full;
  logic             w_empty;
  logic [FIFO_AW:0] w_level;

  assign w_word      = {r_shift, in_data};
  assign w_word_done = in_valid && (r_count == CNT_W'(NIBBLES - 1));
  assign w_pop       = !w_empty && out_ready;
  assign w_drop      = w_word_done && w_full && !w_pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (in_valid) begin
      r_shift <= w_word[W-NIBBLE_W-1:0];
      r_count <= w_word_done ? '0 : r_count + CNT_W'(1);
    end
  end

  // A drop on the same edge as a clear wins so no loss goes unreported.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (w_word_done),
    .i_push_data (w_word),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  assign out_data  = w_head;
  assign out_valid = !w_empty;
  assign level     = w_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer (NIBBLES=4, FIFO_DEPTH=4).
module tb_nibble_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  nibble_packer #(
    .NIBBLES    (4),
    .FIFO_DEPTH (4),
    .FIFO_AW    (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Stimulus helpers; every task starts and ends 1 time unit after a rising edge.
  task automatic nib(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy_last, input logic clr_last);
    logic [15:0] v;
    v = w;
    for (int i = 3; i >= 0; i--) begin
      in_data  = v[4*i +: 4];
      in_valid = 1'b1;
      if (i == 0) begin
        out_ready    = rdy_last;
        overflow_clr = clr_last;
      end
      @(posedge clock); #1;
    end
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    $display("push word %h (level=%0d overflow=%0d)", w, level, overflow);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data   = 4'($urandom_range(0, 15));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0 || level !== 3'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got valid=%b data=%h level=%0d ovf=%b, want 0/0000/0/0",
                 c, out_valid, out_data, level, overflow);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b1;
    @(posedge clock); #1;
    $display("reset released");
  endtask

  task automatic test_basic_pack();
    out_ready = 1'b1;
    nib(4'hA); nib(4'hB); nib(4'hC);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    nib(4'hD);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hABCD || level !== 3'd1) begin
      errors++;
      $display("FAIL basic_word: got valid=%b data=%h level=%0d want 1/abcd/1", out_valid, out_data, level);
    end
    $display("pop word %h", out_data);
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL basic_one_cycle: got valid=%b level=%0d want 0/0", out_valid, level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [4];
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) send_word(exp[i], 1'b0, 1'b0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL bp_full: got level=%0d ovf=%b want 4/0", level, overflow);
    end
    send_word(16'h5555, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL bp_overflow: got level=%0d ovf=%b want 4/1", level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++; $display("FAIL bp_drain%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp[i]);
      end
      $display("pop word %h", out_data);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
    end
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++; $display("FAIL bp_empty: got level=%0d valid=%b data=%h want 0/0/0000", level, out_valid, out_data);
    end
  endtask

  task automatic test_overflow_clr();
    logic [15:0] exp [4];
    exp = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    overflow_clr = 1'b1;
    @(posedge clock); #1;
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    for (int i = 0; i < 4; i++) send_word(exp[i], 1'b0, 1'b0);
    send_word(16'h7777, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++; $display("FAIL ovf_set_wins: got ovf=%b level=%0d want 1/4", overflow, level);
    end
    overflow_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++; $display("FAIL ovf_drain%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp[i]);
      end
      $display("pop word %h", out_data);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      overflow_clr = 1'b0;
    end
    checks++;
    if (overflow !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL ovf_after_drain: got ovf=%b level=%0d want 0/0", overflow, level);
    end
  endtask

  task automatic test_push_pop_full();
    logic [15:0] exp [4];
    exp = '{16'h2222, 16'h3333, 16'h4444, 16'h6666};
    send_word(16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(exp[i], 1'b0, 1'b0);
    send_word(16'h6666, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0 || level !== 3'd4) begin
      errors++; $display("FAIL pp_full: got ovf=%b level=%0d want 0/4", overflow, level);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++; $display("FAIL pp_drain%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp[i]);
      end
      $display("pop word %h", out_data);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_empty_pop();
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL empty_pop: got level=%0d valid=%b want 0/0", level, out_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    nib(4'h9); nib(4'h9);
    reset_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got valid=%b level=%0d ovf=%b want 0/0/0", out_valid, level, overflow);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || level !== 3'd1) begin
      errors++; $display("FAIL midreset_word: got valid=%b data=%h level=%0d want 1/1234/1", out_valid, out_data, level);
    end
    $display("pop word %h", out_data);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_single: got level=%0d valid=%b want 0/0", level, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_overflow_clr();
    test_push_pop_full();
    test_empty_pop();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, want completion before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the 4-bit LFSR output stage.
- Accepts single-cycle-valid 4-bit nibbles and packs NIBBLES of them, MSB-first, into one wide word.
- Buffers completed words in a small synchronous FIFO and presents them on a valid/ready interface to the next consumer (UART/bus bridge).
- Reports FIFO occupancy and a sticky overflow flag.

Parameters:
- NIBBLES, 4, nibbles per output word; output width W = 4*NIBBLES; legal range 2..8.
- FIFO_DEPTH, 4, number of word entries; power of two, at least 2.
- FIFO_AW, 2, log2(FIFO_DEPTH); must be consistent with FIFO_DEPTH.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  4  nibble from the LFSR stage; ignored when in_valid=0.
- in_valid  in  1  qualifies in_data; may be high on any cycle, including back-to-back.
- out_data  out  W  word at the FIFO head; 0 when the FIFO is empty.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both 1 at a rising edge.
- level  out  FIFO_AW+1  number of stored words, 0..FIFO_DEPTH.
- overflow  out  1  sticky; set when a completed word is dropped.
- overflow_clr  in  1  synchronous clear for overflow.

Behaviour:
- Reset (asynchronous assert, synchronous release) clears the following:
  - pack counter and shift register;
  - FIFO pointers and level;
  - out_valid=0, out_data=0, level=0, overflow=0.
  - Any partial word is discarded.
- Packing:
  - Pack counter runs 0..NIBBLES-1.
  - Each edge with in_valid=1 shifts the shift register left 4 and places in_data in bits [3:0].
  - The first nibble of a word therefore ends in out_data[W-1:W-4].
  - When a nibble arrives with count=NIBBLES-1, the word {shift[W-5:0], in_data} is offered to the FIFO on that same edge, and the counter wraps to 0.
- Latency: the word becomes visible at the FIFO head one cycle after the edge that samples its final nibble. out_valid rises after that edge. There is no combinational path from in_* to out_*.
- FIFO:
  - Show-ahead; out_data always reflects the head entry.
  - Pop occurs when out_valid && out_ready.
  - Push occurs when a word completes and either (level < FIFO_DEPTH) or a pop happens on the same edge.
  - Simultaneous push and pop leaves level unchanged, and ordering is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Full:
  - A word completing while level==FIFO_DEPTH with no pop on the same edge is dropped.
  - overflow is set, and FIFO contents are unchanged.
  - The pack counter still wraps, so the next nibble starts a new word.
- Empty: out_ready while out_valid=0 has no effect. level never underflows.
- overflow: if overflow_clr and a new drop occur on the same edge, set wins.
- out_ready toggling mid-stream never corrupts the packing path; packing is independent of output backpressure.
- Mid-operation reset: all buffered and partial data is lost. The first nibble after release begins a fresh word.

Decomposition:
- Package nibble_pkg holds:
  - NIBBLE_W=4;
  - the default NIBBLES and FIFO_DEPTH constants;
  - a clog2 function used to check FIFO_AW.
- Sub-module sync_fifo (parameters WIDTH, DEPTH, AW), instantiated once. It provides:
  - push and pop;
  - show-ahead head;
  - full, empty and level outputs;
  - the same asynchronous active-low reset.
- The packer register and counter stay in nibble_packer.

Test Plan:
- Reset check: hold reset_n=0 with random in_* → out_valid=0, out_data=0, level=0, overflow=0 throughout.
- Basic pack: out_ready=1; nibbles A,B,C,D on 4 consecutive cycles → out_data=16'hABCD with out_valid high for exactly 1 cycle, starting the cycle after D is sampled.
- Backpressure and overflow:
  - out_ready=0; send 5 words 1111,2222,3333,4444,5555 → level=4 and overflow=1 after the 5th word.
  - Then drain with out_ready=1 → words 1111,2222,3333,4444 in order; level ends at 0.
- Push-pop on full: FIFO full; complete word 6666 on the same edge as a pop → overflow stays 0, level stays 4, and 6666 is drained last.
- Reset mid-word: send nibbles 9,9, pulse reset_n low, then send 1,2,3,4 → single word 16'h1234 with no stale data.
- Overflow clear: with overflow=1, pulse overflow_clr → 0. overflow_clr on the same edge as a drop → overflow stays 1.
